// File: rtl/dmem_pkg.sv
// Shared types and byte-enable helper for the sized-access data memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] addr_lo);
    case (mem_size_e'(size))
      SZ_B:    return 4'b0001 << addr_lo;
      SZ_H:    return 4'b0011 << addr_lo;
      SZ_W:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
interface dmem_lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dmem_load_ext.sv
// Lane select and sign/zero extension applied to the registered read word.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
    data_o   = word_i;
    case (mem_size_e'(size_i))
      SZ_B:    data_o = unsigned_i ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SZ_H:    data_o = unsigned_i ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 data memory: sized loads/stores with byte-lane merge, fault detection,
// and a post-reset hardware clear sweep.
//
//   state | meaning
//   CLEAR | zero one word per cycle, requests refused
//   RUN   | accept one request per cycle, 1-cycle response
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk,
  input  logic       reset,
  dmem_lsu_if.slave  bus
);

  state_e          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            clr_we, accept, fault, st_we, ld_re;
  logic [AW-1:0]   widx;
  logic [3:0]      be;
  logic [31:0]     wdata_rep;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     rd_q, ext_data;
  logic            rsp_valid_q, rsp_err_q, rsp_load_q, rsp_uns_q;
  logic [1:0]      rsp_lo_q, rsp_size_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    clr_we        = 1'b0;
    bus.req_ready = 1'b0;
    bus.busy      = 1'b0;
    case (state_q)
      CLEAR: begin
        bus.busy = 1'b1;
        clr_we   = 1'b1;
        idx_d    = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH - 1)) state_d = RUN;
      end
      RUN:     bus.req_ready = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Reset takes priority over a request presented in the same cycle.
  assign accept = bus.req_valid && bus.req_ready && !reset;
  assign widx   = bus.req_addr[AW+1:2];
  assign be     = be_from_size(bus.req_size, bus.req_addr[1:0]);

  always_comb begin
    fault     = 1'b0;
    wdata_rep = bus.req_wdata;
    case (mem_size_e'(bus.req_size))
      SZ_B: wdata_rep = {4{bus.req_wdata[7:0]}};
      SZ_H: begin
        fault     = bus.req_addr[0];
        wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      SZ_W:    fault = |bus.req_addr[1:0];
      default: fault = 1'b1;
    endcase
    if (|bus.req_addr[31:AW+2]) fault = 1'b1;
  end

  assign st_we = accept && bus.req_we && !fault;
  assign ld_re = accept && !bus.req_we && !fault;

  // Array has no reset; the CLEAR sweep zeroes it so it can map to block RAM.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[idx_q] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
    if (ld_re) rd_q <= mem_q[widx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_load_q  <= 1'b0;
      rsp_uns_q   <= 1'b0;
      rsp_lo_q    <= '0;
      rsp_size_q  <= '0;
    end else begin
      rsp_valid_q <= accept;
      if (accept) begin
        rsp_err_q  <= fault;
        rsp_load_q <= !bus.req_we;
        rsp_uns_q  <= bus.req_unsigned;
        rsp_lo_q   <= bus.req_addr[1:0];
        rsp_size_q <= bus.req_size;
      end
    end
  end

  dmem_load_ext u_load_ext (
    .word_i     (rd_q),
    .addr_lo_i  (rsp_lo_q),
    .size_i     (rsp_size_q),
    .unsigned_i (rsp_uns_q),
    .data_o     (ext_data)
  );

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_valid_q && rsp_err_q;
  assign bus.rsp_rdata = (rsp_valid_q && rsp_load_q && !rsp_err_q) ? ext_data : '0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with DEPTH=16; expected values hand-computed.
module tb_dmem_lsu;

  localparam int DEPTH = 16;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  dmem_lsu_if bus ();

  dmem_lsu #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Presents one request for a single edge; returns what is visible just after it.
  task automatic xfer(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic v, output logic [31:0] rd, output logic e);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    v  = bus.rsp_valid;
    rd = bus.rsp_rdata;
    e  = bus.rsp_err;
  endtask

  task automatic test_reset();
    logic v, e;
    logic [31:0] rd;
    int cycles;
    int stray;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (bus.busy !== 1'b1 || bus.req_ready !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.rsp_rdata !== 32'h0 || bus.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b ready=%b v=%b rdata=%h err=%b, want 1 0 0 00000000 0",
               bus.busy, bus.req_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err);
    end
    reset = 1'b0;
    // A store presented during the sweep must be ignored.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h3C;
    bus.req_wdata = 32'hFFFF_FFFF;
    cycles = 0;
    stray  = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      if (bus.req_ready !== 1'b0) stray++;
      @(posedge clk);
      #1;
      cycles++;
      if (bus.rsp_valid !== 1'b0) stray++;
    end
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    n_tests++;
    if (cycles != DEPTH) begin
      n_fail++;
      $display("FAIL sweep_len: got %0d cycles, want %0d", cycles, DEPTH);
    end
    n_tests++;
    if (stray != 0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_quiet: got %0d ready/rsp glitches, ready=%b, want 0 and ready=1", stray, bus.req_ready);
    end
    xfer(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, v, rd, e);
    n_tests++;
    if (v !== 1'b1 || rd !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_0x3c_cleared: got v=%b rdata=%h err=%b, want 1 00000000 0", v, rd, e);
    end
  endtask

  task automatic test_load_ext();
    logic v, e;
    logic [31:0] rd;
    logic [1:0]  sz  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd0};
    logic        un  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad  [5] = '{32'h13, 32'h13, 32'h12, 32'h10, 32'h10};
    logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8081, 32'h0000_8283, 32'hFFFF_FF83};
    xfer(1'b1, 2'd2, 1'b0, 32'h10, 32'h8081_8283, v, rd, e);
    n_tests++;
    if (v !== 1'b1 || rd !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_0x10: got v=%b rdata=%h err=%b, want 1 00000000 0", v, rd, e);
    end
    for (int i = 0; i < 5; i++) begin
      xfer(1'b0, sz[i], un[i], ad[i], 32'h0, v, rd, e);
      n_tests++;
      if (v !== 1'b1 || rd !== exp[i] || e !== 1'b0) begin
        n_fail++;
        $display("FAIL load_ext[%0d] size=%0d uns=%b addr=%h: got v=%b rdata=%h err=%b, want 1 %h 0",
                 i, sz[i], un[i], ad[i], v, rd, e, exp[i]);
      end
    end
  endtask

  task automatic test_byte_merge();
    logic v, e;
    logic [31:0] rd;
    xfer(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, v, rd, e);
    xfer(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA, v, rd, e);
    xfer(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, v, rd, e);
    n_tests++;
    if (v !== 1'b1 || rd !== 32'h1122_AA44 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_merge: got v=%b rdata=%h err=%b, want 1 1122aa44 0", v, rd, e);
    end
    xfer(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000_BEEF, v, rd, e);
    xfer(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, v, rd, e);
    n_tests++;
    if (v !== 1'b1 || rd !== 32'hBEEF_AA44 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_merge: got v=%b rdata=%h err=%b, want 1 beefaa44 0", v, rd, e);
    end
  endtask

  task automatic test_faults();
    logic v, e;
    logic [31:0] rd;
    logic        we [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [1:0]  sz [5] = '{2'd2, 2'd1, 2'd2, 2'd3, 2'd2};
    logic [31:0] ad [5] = '{32'h02, 32'h11, DEPTH * 4, 32'h10, DEPTH * 4};
    for (int i = 0; i < 5; i++) begin
      xfer(we[i], sz[i], 1'b0, ad[i], 32'hFFFF_FFFF, v, rd, e);
      n_tests++;
      if (v !== 1'b1 || rd !== 32'h0 || e !== 1'b1) begin
        n_fail++;
        $display("FAIL fault[%0d] we=%b size=%0d addr=%h: got v=%b rdata=%h err=%b, want 1 00000000 1",
                 i, we[i], sz[i], ad[i], v, rd, e);
      end
      xfer(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, v, rd, e);
      n_tests++;
      if (v !== 1'b1 || rd !== 32'h8081_8283 || e !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_followup[%0d]: got v=%b rdata=%h err=%b, want 1 80818283 0", i, v, rd, e);
      end
    end
    // An out-of-range store must not alias onto word 0.
    xfer(1'b0, 2'd2, 1'b0, 32'h00, 32'h0, v, rd, e);
    n_tests++;
    if (v !== 1'b1 || rd !== 32'h0 || e !== 1'b0) begin
      n_fail++;
      $display("FAIL no_alias_0x00: got v=%b rdata=%h err=%b, want 1 00000000 0", v, rd, e);
    end
  endtask

  task automatic test_back_to_back();
    logic v1, v2, v3, e2;
    logic [31:0] rd2;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h08;
    bus.req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    v1 = bus.rsp_valid;
    bus.req_we    = 1'b0;
    bus.req_wdata = 32'h0;
    @(posedge clk);
    #1;
    v2  = bus.rsp_valid;
    rd2 = bus.rsp_rdata;
    e2  = bus.rsp_err;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    v3 = bus.rsp_valid;
    n_tests++;
    if (v1 !== 1'b1 || v2 !== 1'b1 || v3 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_valid: got %b%b%b, want 110", v1, v2, v3);
    end
    n_tests++;
    if (rd2 !== 32'hDEAD_BEEF || e2 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_data: got rdata=%h err=%b, want deadbeef 0", rd2, e2);
    end
  endtask

  task automatic test_reset_run();
    logic v, e;
    logic [31:0] rd;
    logic [31:0] ad [3] = '{32'h08, 32'h10, 32'h20};
    int cycles;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_run: got v=%b busy=%b ready=%b, want 0 1 0", bus.rsp_valid, bus.busy, bus.req_ready);
    end
    // Request alongside reset: reset wins.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h3C;
    bus.req_wdata = 32'h1234_5678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    reset = 1'b0;
    n_tests++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vs_req: got v=%b, want 0", bus.rsp_valid);
    end
    cycles = 0;
    while (bus.busy === 1'b1 && cycles < 100) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    n_tests++;
    if (cycles != DEPTH) begin
      n_fail++;
      $display("FAIL resweep_len: got %0d cycles, want %0d", cycles, DEPTH);
    end
    for (int i = 0; i < 3; i++) begin
      xfer(1'b0, 2'd2, 1'b0, ad[i], 32'h0, v, rd, e);
      n_tests++;
      if (v !== 1'b1 || rd !== 32'h0 || e !== 1'b0) begin
        n_fail++;
        $display("FAIL recleared[%0d] addr=%h: got v=%b rdata=%h err=%b, want 1 00000000 0", i, ad[i], v, rd, e);
      end
    end
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_ext();
    test_byte_merge();
    test_faults();
    test_back_to_back();
    test_reset_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
